// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
// Latency: n/a (constants, state enum and op-code decode helpers only).
// Backpressure: n/a.
package muldiv_pkg;

  // Op codes carried on multControl
  localparam logic [4:0] OP_MUL    = 5'h0A;
  localparam logic [4:0] OP_MULH   = 5'h0B;
  localparam logic [4:0] OP_MULHSU = 5'h0C;
  localparam logic [4:0] OP_MULHU  = 5'h0D;
  localparam logic [4:0] OP_DIV    = 5'h0E;
  localparam logic [4:0] OP_DIVU   = 5'h0F;
  localparam logic [4:0] OP_REM    = 5'h10;
  localparam logic [4:0] OP_REMU   = 5'h11;

  // One result bit is produced per CALC cycle
  localparam int ITERATIONS = 32;
  localparam int CNT_W      = $clog2(ITERATIONS);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  function automatic logic op_is_legal(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  function automatic logic op_is_div(input logic [4:0] op);
    return (op >= OP_DIV) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Iterative RISC-V M-extension unit: radix-2 shift-add multiply / restoring divide on magnitudes, sign fix-up at the end.
// Latency: 34 cycles accept-to-done (32 CALC + 1 FIX + DONE); div-by-zero, signed overflow and illegal ops finish in 1.
// Backpressure: start is taken only in IDLE or DONE; a start while busy is dropped, there is no queueing.
// Ports: clk/reset (sync, active-high); start+multControl+A+B launch an op; busy high in CALC/FIX;
//        done pulses one cycle with multResult (held until the next done) and illegal (bad op code).
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       multControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] multResult,
  output logic             illegal
);

  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  state_t             state_q, state_d;
  logic [4:0]         op_q, op_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   hi_q, hi_d;       // product high half / partial remainder
  logic [WIDTH-1:0]   lo_q, lo_d;       // multiplier shifting out / quotient shifting in
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_main_q, neg_main_d;  // negate product or quotient
  logic               neg_rem_q, neg_rem_d;    // remainder follows dividend sign
  logic [WIDTH-1:0]   result_q, result_d;
  logic               illegal_q, illegal_d;

  // ---------------- accept-time decode ----------------
  logic             a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             legal, is_div_in, div_zero, sgn_ovf, bypass;
  logic [WIDTH-1:0] bypass_res;

  always_comb begin
    a_signed = (multControl == OP_MUL) || (multControl == OP_MULH) ||
               (multControl == OP_MULHSU) || (multControl == OP_DIV) ||
               (multControl == OP_REM);
    b_signed = (multControl == OP_MUL) || (multControl == OP_MULH) ||
               (multControl == OP_DIV) || (multControl == OP_REM);
    a_neg    = a_signed & A[WIDTH-1];
    b_neg    = b_signed & B[WIDTH-1];
    a_mag    = a_neg ? -A : A;
    b_mag    = b_neg ? -B : B;

    legal     = op_is_legal(multControl);
    is_div_in = op_is_div(multControl);
    div_zero  = is_div_in && (B == '0);
    sgn_ovf   = ((multControl == OP_DIV) || (multControl == OP_REM)) &&
                (A == MIN_NEG) && (B == ALL_ONES);
    bypass    = !legal || div_zero || sgn_ovf;

    bypass_res = '0;
    if (!legal) begin
      bypass_res = '0;
    end else if (div_zero) begin
      bypass_res = ((multControl == OP_DIV) || (multControl == OP_DIVU)) ? ALL_ONES : A;
    end else if (sgn_ovf) begin
      bypass_res = (multControl == OP_DIV) ? MIN_NEG : '0;
    end
  end

  // ---------------- single iteration step ----------------
  // One 33-bit adder serves both algorithms. For divide it subtracts and
  // the carry out (bit WIDTH+1) is the "no borrow" quotient bit.
  logic               run_div;
  logic [WIDTH:0]     add_x, add_y;
  logic [WIDTH+1:0]   add_sum;
  logic               quo_bit;
  logic [WIDTH:0]     mul_top;
  logic [WIDTH-1:0]   step_hi, step_lo;

  always_comb begin
    run_div = op_is_div(op_q);
    add_x   = run_div ? {hi_q, lo_q[WIDTH-1]} : {1'b0, hi_q};
    add_y   = {1'b0, opnd_q};
    add_sum = {1'b0, add_x} + {1'b0, (run_div ? ~add_y : add_y)} +
              {{(WIDTH+1){1'b0}}, run_div};

    quo_bit = add_sum[WIDTH+1];
    mul_top = lo_q[0] ? add_sum[WIDTH:0] : {1'b0, hi_q};

    if (run_div) begin
      // Restore on borrow: keep the shifted remainder unchanged
      step_hi = quo_bit ? add_sum[WIDTH-1:0] : add_x[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], quo_bit};
    end else begin
      // Add-then-shift-right of the {carry, hi, lo} product register
      step_hi = mul_top[WIDTH:1];
      step_lo = {mul_top[0], lo_q[WIDTH-1:1]};
    end
  end

  // ---------------- sign fix-up and result select ----------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_res;

  always_comb begin
    prod_fix = neg_main_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo_fix  = neg_main_q ? -lo_q : lo_q;
    rem_fix  = neg_rem_q  ? -hi_q : hi_q;
    unique case (op_q)
      OP_MUL:                        fix_res = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:               fix_res = quo_fix;
      default:                       fix_res = rem_fix;
    endcase
  end

  // ---------------- FSM next state ----------------
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    opnd_d     = opnd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    neg_main_d = neg_main_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    illegal_d  = 1'b0;   // only ever high alongside done

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          op_d       = multControl;
          opnd_d     = b_mag;
          hi_d       = '0;
          lo_d       = a_mag;
          cnt_d      = '0;
          neg_main_d = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          if (bypass) begin
            state_d   = DONE;
            result_d  = bypass_res;
            illegal_d = !legal;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERATIONS - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d  = DONE;
        result_d = fix_res;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      opnd_q     <= opnd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      cnt_q      <= cnt_d;
      neg_main_q <= neg_main_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      illegal_q  <= illegal_d;
    end
  end

  assign busy       = (state_q == CALC) || (state_q == FIX);
  assign done       = (state_q == DONE);
  assign multResult = result_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  multControl;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] multResult;
  logic        illegal;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .multControl(multControl),
    .A          (A),
    .B          (B),
    .busy       (busy),
    .done       (done),
    .multResult (multResult),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Launch one op from the current cycle (IDLE or DONE), scramble the inputs
  // right after accept, optionally pulse start mid-CALC with an illegal op,
  // then measure accept-to-done latency and busy cycles.
  task automatic run_op(input string tag, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_ill,
                        input int exp_lat, input bit mid_start);
    int lat;
    int nbusy;
    logic [31:0] prev;
    prev = multResult;
    start = 1'b1; multControl = op; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; multControl = 5'h1F; A = $urandom; B = 32'h0;
    lat = 1; nbusy = 0;
    while (!done && lat < 80) begin
      if (busy) nbusy++;
      if (lat == 10) begin
        check({tag, "_hold"}, multResult, prev);
        if (mid_start) start = 1'b1;
      end
      if (lat == 11) start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'(exp_lat - 1));
    check_bit({tag, "_busy_at_done"}, busy, 1'b0);
    check({tag, "_res"}, multResult, exp_res);
    check_bit({tag, "_illegal"}, illegal, exp_ill);
  endtask

  initial begin
    bit saw_done;

    // Reset wins over a simultaneous start
    reset = 1'b1; start = 1'b1; multControl = OP_DIVU; A = 32'd5; B = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_done", done, 1'b0);
    check_bit("rst_illegal", illegal, 1'b0);
    check("rst_result", multResult, 32'h0);
    reset = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // mul 7 * -3, from IDLE, with an ignored illegal start mid-CALC
    run_op("mul_7_m3", OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 34, 1'b1);
    @(posedge clk); #1;
    check_bit("done_pulse_width", done, 1'b0);
    check("result_held", multResult, 32'hFFFFFFEB);

    // Multiply variants; these run back-to-back from DONE
    run_op("mulhu_ff", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 34, 1'b0);
    run_op("mulh_ff", OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 34, 1'b0);
    run_op("mulhsu_ff", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 34, 1'b0);
    run_op("mulh_min", OP_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 34, 1'b0);
    run_op("mul_zero", OP_MUL, 32'h0, 32'd5, 32'h0, 1'b0, 34, 1'b0);

    // Divide variants
    run_op("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 34, 1'b1);
    run_op("rem_m7_2", OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 34, 1'b0);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 34, 1'b0);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 34, 1'b0);

    // Abort: div in flight, ignored start at N+10, reset at N+20
    start = 1'b1; multControl = OP_DIV; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    saw_done = 1'b0;
    for (int k = 1; k < 20; k++) begin
      if (done) saw_done = 1'b1;
      if (k == 9) begin
        start = 1'b1; multControl = OP_DIVU; A = 32'd9; B = 32'd0;
      end
      if (k == 10) start = 1'b0;
      if (k == 15) check_bit("abort_still_busy", busy, 1'b1);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_bit("abort_busy", busy, 1'b0);
    check_bit("abort_done", done, 1'b0);
    check_bit("abort_illegal", illegal, 1'b0);
    check("abort_result", multResult, 32'h0);
    for (int k = 0; k < 40; k++) begin
      if (done) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    check_bit("abort_no_done", saw_done, 1'b0);
    run_op("mul_3_4", OP_MUL, 32'd3, 32'd4, 32'd12, 1'b0, 34, 1'b0);

    // Bypass cases, back-to-back from DONE
    run_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b0, 1, 1'b0);
    run_op("remu_by0", OP_REMU, 32'd5, 32'd0, 32'd5, 1'b0, 1, 1'b0);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1, 1'b0);
    run_op("rem_ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1, 1'b0);
    run_op("mul_after", OP_MUL, 32'd6, 32'd7, 32'd42, 1'b0, 34, 1'b0);
    run_op("illegal_1f", 5'h1F, 32'd123, 32'd456, 32'h0, 1'b1, 1, 1'b0);
    @(posedge clk); #1;
    check_bit("illegal_clears", illegal, 1'b0);
    check_bit("idle_after_illegal", done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
